issue_pair_ctrl: RTL and testbench



---
 rtl/issue_pair_ctrl_if.sv | 22 ++
 rtl/issue_pair_ctrl.sv | 154 +++++++++++++++
 tb/tb_issue_pair_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/issue_pair_ctrl_if.sv
// Fetch-to-issue bus for issue_pair_ctrl: the fetched pair and datapath status in,
// the lane instructions and pc-step/hold controls out.
interface issue_pair_ctrl_if;
  logic [31:0] inst_f1;
  logic [31:0] inst_f2;
  logic        redirect;
  logic        stall_in;
  logic [31:0] inst_alp;
  logic [31:0] inst_bta;
  logic        is_plus8;
  logic        bubble_req;

  modport master (
    output inst_f1, inst_f2, redirect, stall_in,
    input  inst_alp, inst_bta, is_plus8, bubble_req
  );

  modport slave (
    input  inst_f1, inst_f2, redirect, stall_in,
    output inst_alp, inst_bta, is_plus8, bubble_req
  );
endinterface

// File: rtl/issue_pair_ctrl.sv
// Dual-issue pairing and cross-lane load-use controller for the alp/bta core.
// Optional performance counters are enabled by defining ISSUE_PERF_CNT_EN.
module issue_pair_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  issue_pair_ctrl_if.slave  bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       dual_cnt,
  output logic [31:0]       single_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam int unsigned OPW = 7;
  localparam int unsigned RW  = 5;

  localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPW-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPW-1:0] OP_BR    = 7'b1100011;
  localparam logic [OPW-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OPW-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OPW-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OPW-1:0] OP_R     = 7'b0110011;

  typedef enum logic { S_WARM, S_RUN } state_t;
  typedef enum logic [1:0] { D_BUBBLE, D_DUAL, D_SINGLE } dec_t;

  state_t        state;
  dec_t          dec;
  logic          ld_v_a, ld_v_b;
  logic [RW-1:0] ld_rd_a, ld_rd_b;

  function automatic logic rd_rs1(input logic [OPW-1:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic rd_rs2(input logic [OPW-1:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BR);
  endfunction

  function automatic logic wr_rd(input logic [OPW-1:0] op, input logic [RW-1:0] rd);
    return !(op == OP_STORE || op == OP_BR) && (rd != '0);
  endfunction

  function automatic logic is_ctl(input logic [OPW-1:0] op);
    return (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic is_mem(input logic [OPW-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  logic [OPW-1:0] op1, op2, op_alp, op_bta;
  logic [RW-1:0]  rd1, rs1_1, rs2_1, rd2, rs1_2, rs2_2, rd_alp, rd_bta;

  assign op1    = bus.inst_f1[6:0];
  assign rd1    = bus.inst_f1[11:7];
  assign rs1_1  = bus.inst_f1[19:15];
  assign rs2_1  = bus.inst_f1[24:20];
  assign op2    = bus.inst_f2[6:0];
  assign rd2    = bus.inst_f2[11:7];
  assign rs1_2  = bus.inst_f2[19:15];
  assign rs2_2  = bus.inst_f2[24:20];
  assign op_alp = bus.inst_alp[6:0];
  assign rd_alp = bus.inst_alp[11:7];
  assign op_bta = bus.inst_bta[6:0];
  assign rd_bta = bus.inst_bta[11:7];

  // Funct/immediate fields play no part in pairing.
  logic unused_fields_c;
  assign unused_fields_c = ^{bus.inst_f1[31:25], bus.inst_f1[14:12],
                             bus.inst_f2[31:25], bus.inst_f2[14:12],
                             bus.inst_alp[31:12], bus.inst_bta[31:12]};

  // Scoreboard match against the loads now sitting in ID.
  logic hit1, hit2, f1_wr, f2_wr, raw12, waw12, pair_ok;

  always_comb begin
    hit1 = (rd_rs1(op1) && ((ld_v_a && rs1_1 == ld_rd_a) || (ld_v_b && rs1_1 == ld_rd_b))) ||
           (rd_rs2(op1) && ((ld_v_a && rs2_1 == ld_rd_a) || (ld_v_b && rs2_1 == ld_rd_b)));
    hit2 = (rd_rs1(op2) && ((ld_v_a && rs1_2 == ld_rd_a) || (ld_v_b && rs1_2 == ld_rd_b))) ||
           (rd_rs2(op2) && ((ld_v_a && rs2_2 == ld_rd_a) || (ld_v_b && rs2_2 == ld_rd_b)));
    f1_wr   = wr_rd(op1, rd1);
    f2_wr   = wr_rd(op2, rd2);
    raw12   = f1_wr && ((rd_rs1(op2) && rs1_2 == rd1) || (rd_rs2(op2) && rs2_2 == rd1));
    waw12   = f1_wr && f2_wr && (rd1 == rd2);
    pair_ok = !is_ctl(op1) && !is_ctl(op2) && !(is_mem(op1) && is_mem(op2)) &&
              !raw12 && !waw12 && !hit2;
  end

  // Zero-latency decision: pc_next depends on is_plus8 in the same cycle.
  always_comb begin
    dec            = D_SINGLE;
    bus.inst_alp   = NOP_INST;
    bus.inst_bta   = NOP_INST;
    bus.is_plus8   = 1'b0;
    bus.bubble_req = 1'b0;
    if (state == S_WARM || hit1) begin
      dec            = D_BUBBLE;
      bus.bubble_req = 1'b1;
    end else if (pair_ok) begin
      dec          = D_DUAL;
      bus.inst_alp = bus.inst_f1;
      bus.inst_bta = bus.inst_f2;
      bus.is_plus8 = 1'b1;
    end else begin
      bus.inst_alp = bus.inst_f1;
    end
  end

  // Warm-up state and load scoreboard for the pair entering ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_WARM;
      ld_v_a  <= 1'b0;
      ld_rd_a <= '0;
      ld_v_b  <= 1'b0;
      ld_rd_b <= '0;
    end else begin
      state <= S_RUN;
      if (bus.redirect) begin
        ld_v_a <= 1'b0;
        ld_v_b <= 1'b0;
      end else if (!bus.stall_in) begin
        ld_v_a  <= (op_alp == OP_LOAD) && (rd_alp != '0);
        ld_rd_a <= rd_alp;
        ld_v_b  <= (op_bta == OP_LOAD) && (rd_bta != '0);
        ld_rd_b <= rd_bta;
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Issue-mix counters; stalled cycles repeat a decision and are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
      bubble_cnt <= '0;
    end else if (!bus.stall_in) begin
      case (dec)
        D_DUAL:   dual_cnt   <= dual_cnt + 32'd1;
        D_SINGLE: single_cnt <= single_cnt + 32'd1;
        default:  bubble_cnt <= bubble_cnt + 32'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_issue_pair_ctrl.sv
// Directed self-checking bench for issue_pair_ctrl; counter checks run when
// ISSUE_PERF_CNT_EN is defined.
module tb_issue_pair_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI1_1  = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADDI2_2  = 32'h0020_0113; // addi x2,x0,2
  localparam logic [31:0] ADDI2_0  = 32'h0000_0113; // addi x2,x0,0
  localparam logic [31:0] ADDI5_1  = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] ADD6_55  = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] LW7      = 32'h0000_A383; // lw x7,0(x1)
  localparam logic [31:0] ADD8_7   = 32'h0003_8433; // add x8,x7,x0
  localparam logic [31:0] ADDI9_1  = 32'h0010_0493; // addi x9,x0,1
  localparam logic [31:0] SW1_2    = 32'h0011_2023; // sw x1,0(x2)
  localparam logic [31:0] SW0_2    = 32'h0001_2023; // sw x0,0(x2)
  localparam logic [31:0] LW3      = 32'h0041_2183; // lw x3,4(x2)
  localparam logic [31:0] BEQ      = 32'h0020_8463; // beq x1,x2,8
  localparam logic [31:0] ADDI4_1  = 32'h0010_0213; // addi x4,x0,1
  localparam logic [31:0] ADDI4_2  = 32'h0020_0213; // addi x4,x0,2

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  issue_pair_ctrl_if bus ();

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] dual_cnt, single_cnt, bubble_cnt;
  issue_pair_ctrl dut (.clk(clk), .rst(rst), .bus(bus),
                       .dual_cnt(dual_cnt), .single_cnt(single_cnt), .bubble_cnt(bubble_cnt));
`else
  issue_pair_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] alp, input logic [31:0] bta,
                            input logic p8, input logic bub);
    check32({tag, ".alp"}, bus.inst_alp, alp);
    check32({tag, ".bta"}, bus.inst_bta, bta);
    check32({tag, ".p8"},  32'(bus.is_plus8), 32'(p8));
    check32({tag, ".bub"}, 32'(bus.bubble_req), 32'(bub));
  endtask

  // Present one fetch pair mid-cycle; outputs are sampled 1 ns later.
  task automatic drive(input logic [31:0] f1, input logic [31:0] f2,
                       input logic redir, input logic stall);
    @(negedge clk);
    bus.inst_f1  = f1;
    bus.inst_f2  = f2;
    bus.redirect = redir;
    bus.stall_in = stall;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    bus.inst_f1  = ADDI1_1;
    bus.inst_f2  = ADDI2_2;
    bus.redirect = 1'b0;
    bus.stall_in = 1'b0;
    #3;
    expect_out("in_reset", NOP, NOP, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    release_reset();
    expect_out("warm", NOP, NOP, 1'b0, 1'b1);

    drive(ADDI1_1, ADDI2_2, 1'b0, 1'b0); expect_out("first_dual", ADDI1_1, ADDI2_2, 1'b1, 1'b0);
    drive(ADDI5_1, ADD6_55, 1'b0, 1'b0); expect_out("raw_pair",   ADDI5_1, NOP, 1'b0, 1'b0);

    // Load in bta lane blocks a dependent f1 next cycle only.
    drive(ADDI2_0, LW7,    1'b0, 1'b0); expect_out("ld_b_issue", ADDI2_0, LW7, 1'b1, 1'b0);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("ld_use",     NOP, NOP, 1'b0, 1'b1);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("after_bub",  ADD8_7, ADDI9_1, 1'b1, 1'b0);

    drive(SW1_2, LW3,       1'b0, 1'b0); expect_out("mem_mem", SW1_2, NOP, 1'b0, 1'b0);
    drive(BEQ, ADDI1_1,     1'b0, 1'b0); expect_out("ctl_f1",  BEQ, NOP, 1'b0, 1'b0);
    drive(ADDI4_1, ADDI4_2, 1'b0, 1'b0); expect_out("waw",     ADDI4_1, NOP, 1'b0, 1'b0);

    // Redirect flushes the scoreboard even while the bubble is shown.
    drive(ADDI2_0, LW7,    1'b0, 1'b0); expect_out("rd_ld",    ADDI2_0, LW7, 1'b1, 1'b0);
    drive(ADD8_7, ADDI9_1, 1'b1, 1'b0); expect_out("rd_bub",   NOP, NOP, 1'b0, 1'b1);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("rd_clear", ADD8_7, ADDI9_1, 1'b1, 1'b0);

    // Stall holds the scoreboard, so the bubble repeats.
    drive(ADDI2_0, LW7,    1'b0, 1'b0); expect_out("st_ld",   ADDI2_0, LW7, 1'b1, 1'b0);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b1); expect_out("st_bub1", NOP, NOP, 1'b0, 1'b1);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("st_bub2", NOP, NOP, 1'b0, 1'b1);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("st_go",   ADD8_7, ADDI9_1, 1'b1, 1'b0);

    // Redirect beats stall.
    drive(ADDI2_0, LW7,    1'b0, 1'b0); expect_out("rs_ld",  ADDI2_0, LW7, 1'b1, 1'b0);
    drive(ADD8_7, ADDI9_1, 1'b1, 1'b1); expect_out("rs_bub", NOP, NOP, 1'b0, 1'b1);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("rs_go",  ADD8_7, ADDI9_1, 1'b1, 1'b0);

    // Load in alp lane, and a hit on f2 only downgrades to single.
    drive(LW7, SW0_2,      1'b0, 1'b0); expect_out("ld_a_issue", LW7, NOP, 1'b0, 1'b0);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("ld_a_use",   NOP, NOP, 1'b0, 1'b1);
    drive(ADDI2_0, LW7,    1'b0, 1'b0); expect_out("h2_ld",      ADDI2_0, LW7, 1'b1, 1'b0);
    drive(ADDI1_1, ADD8_7, 1'b0, 1'b0); expect_out("hit_f2",     ADDI1_1, NOP, 1'b0, 1'b0);

    // Reset mid-run returns to WARM and drops the pending load.
    drive(ADDI2_0, LW7, 1'b0, 1'b0);    expect_out("mr_ld", ADDI2_0, LW7, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.inst_f1 = ADD8_7;
    bus.inst_f2 = ADDI9_1;
    #1;
    expect_out("mr_in_reset", NOP, NOP, 1'b0, 1'b1);
    release_reset();
    expect_out("mr_warm", NOP, NOP, 1'b0, 1'b1);
    drive(ADD8_7, ADDI9_1, 1'b0, 1'b0); expect_out("mr_go", ADD8_7, ADDI9_1, 1'b1, 1'b0);

`ifdef ISSUE_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    check32("cnt_rst_dual",   dual_cnt,   32'd0);
    check32("cnt_rst_single", single_cnt, 32'd0);
    check32("cnt_rst_bubble", bubble_cnt, 32'd0);
    release_reset();                                   // WARM: bubble 1
    for (int i = 0; i < 9; i++)
      drive(ADDI1_1, ADDI2_2, 1'b0, 1'b0);             // dual 1..9
    drive(ADDI2_0, LW7,     1'b0, 1'b0);               // dual 10
    drive(ADD8_7, ADDI9_1,  1'b0, 1'b0);               // bubble 2
    drive(ADD8_7, ADDI9_1,  1'b0, 1'b1);               // stalled, not counted
    drive(LW7, SW0_2,       1'b0, 1'b0);               // single 1
    drive(ADD8_7, ADDI9_1,  1'b0, 1'b0);               // bubble 3
    drive(SW1_2, LW3,       1'b0, 1'b0);               // single 2
    drive(BEQ, ADDI1_1,     1'b0, 1'b0);               // single 3
    @(negedge clk);
    #1;
    check32("cnt_dual",   dual_cnt,   32'd10);
    check32("cnt_single", single_cnt, 32'd3);
    check32("cnt_bubble", bubble_cnt, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
